uart_fp_operand_assembler: RTL and testbench

- Sits directly downstream of the UART receiver in the floating-point test path.
- Consumes received bytes (8-bit data plus a one-cycle done pulse) and packs them into two 32-bit IEEE-754 operands, A then B.
- Presents the pair to the FP datapath over a valid/ready handshake.
- Detects inter-byte gap timeouts and bytes that are dropped while a pair is pending.

---
 rtl/uart_fp_pkg.sv | 17 +
 rtl/uart_fp_operand_assembler_gap_timer.sv | 32 +++
 rtl/uart_fp_operand_assembler.sv | 156 +++++++++++++++
 tb/tb_uart_fp_operand_assembler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fp_pkg.sv
// Shared types and constants for the UART floating-point operand assembler.
package uart_fp_pkg;

    localparam int SIZE_FP      = 32;
    localparam int BYTES_PER_OP = 4;
    localparam int CNT_W        = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT_A,
        COLLECT_B,
        HOLD
    } state_t;

endpackage

// File: rtl/uart_fp_operand_assembler_gap_timer.sv
// Inter-byte gap timer: counts oversample ticks while enabled, pulses expire on the limit tick.
module uart_gap_timer #(
    parameter int TIMEOUT_TICKS = 704
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic enable,
    input  logic clear,
    input  logic i_stick,
    output logic expire
);

    localparam bit ACTIVE = (TIMEOUT_TICKS > 0);
    localparam int LIMIT  = ACTIVE ? TIMEOUT_TICKS : 1;
    localparam int CW     = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;

    // A byte arriving on the limit tick clears the count, so it never expires.
    assign expire = ACTIVE && enable && !clear && i_stick && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (!ACTIVE || !enable || clear || expire) begin
            cnt_q <= '0;
        end else if (i_stick) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_fp_operand_assembler.sv
// Packs received UART bytes into an A/B pair of FP operands and hands the pair
// to the FP datapath over valid/ready, flagging gap timeouts and dropped bytes.
module uart_fp_operand_assembler #(
    parameter int SIZE_DATA      = 8,
    parameter int SIZE_FP        = 32,
    parameter bit BYTE_LSB_FIRST = 1'b1,
    parameter int TIMEOUT_TICKS  = 704
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stick,
    input  logic [SIZE_DATA-1:0] i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_op_ready,
    output logic [SIZE_FP-1:0]   o_op_a,
    output logic [SIZE_FP-1:0]   o_op_b,
    output logic                 o_op_valid,
    output logic                 o_full,
    output logic                 o_timeout_err,
    output logic                 o_drop_err
);

    import uart_fp_pkg::*;

    localparam cnt_t LAST = cnt_t'(BYTES_PER_OP - 1);

    state_t             state_q, state_d;
    cnt_t               cnt_q, cnt_d;
    logic [SIZE_FP-1:0] op_a_q, op_b_q;
    logic               wr_a, wr_b;
    logic               timeout_d, drop_d;
    logic               timeout_q, drop_q;
    logic               in_collect;
    logic               expire;

    assign in_collect = (state_q == COLLECT_A) || (state_q == COLLECT_B);

    uart_gap_timer #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_gap_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .enable  (in_collect),
        .clear   (i_rx_done),
        .i_stick (i_stick),
        .expire  (expire)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_a      = 1'b0;
        wr_b      = 1'b0;
        timeout_d = 1'b0;
        drop_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_rx_done) begin
                    wr_a    = 1'b1;
                    cnt_d   = cnt_t'(1);
                    state_d = COLLECT_A;
                end
            end
            COLLECT_A: begin
                if (i_rx_done) begin
                    wr_a = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = COLLECT_B;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end else if (expire) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            COLLECT_B: begin
                if (i_rx_done) begin
                    wr_b = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end else if (expire) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            HOLD: begin
                // A byte landing on the handshake cycle starts the next pair (cnt_q is 0 here).
                if (i_op_ready) begin
                    if (i_rx_done) begin
                        wr_a    = 1'b1;
                        cnt_d   = cnt_t'(1);
                        state_d = COLLECT_A;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (i_rx_done) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
        end
    end

    // Byte lanes are overwritten in place; no clear between pairs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_a_q <= '0;
            op_b_q <= '0;
        end else begin
            for (int k = 0; k < BYTES_PER_OP; k++) begin
                if (cnt_q == cnt_t'(k)) begin
                    if (wr_a) begin
                        op_a_q[(BYTE_LSB_FIRST ? k : BYTES_PER_OP - 1 - k) * SIZE_DATA +: SIZE_DATA] <= i_rx_data;
                    end
                    if (wr_b) begin
                        op_b_q[(BYTE_LSB_FIRST ? k : BYTES_PER_OP - 1 - k) * SIZE_DATA +: SIZE_DATA] <= i_rx_data;
                    end
                end
            end
        end
    end

    assign o_op_a        = op_a_q;
    assign o_op_b        = op_b_q;
    assign o_op_valid    = (state_q == HOLD);
    assign o_full        = (state_q == HOLD);
    assign o_timeout_err = timeout_q;
    assign o_drop_err    = drop_q;

endmodule

// File: tb/tb_uart_fp_operand_assembler.sv
// Scoreboard bench: two assemblers (LSB-first with 8-tick timeout, MSB-first with timeout off).
module tb_uart_fp_operand_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  stick = '0;
    logic [1:0]  rx_done = '0;
    logic [1:0]  ready = '0;
    logic [7:0]  rx_data0 = '0, rx_data1 = '0;
    logic [31:0] op_a0, op_b0, op_a1, op_b1;
    logic        valid0, full0, to0, drop0;
    logic        valid1, full1, to1, drop1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, one entry per DUT
    bit          lsb[2] = '{1'b1, 1'b0};
    int          tt[2]  = '{8, 0};
    bit          held[2];
    int          nb[2];
    int          gap[2];
    logic [7:0]  bq[2][8];
    bit          exp_drop[2];
    bit          exp_to[2];
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    always #5 clk = ~clk;

    uart_fp_operand_assembler #(
        .SIZE_DATA(8), .SIZE_FP(32), .BYTE_LSB_FIRST(1'b1), .TIMEOUT_TICKS(8)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .i_stick(stick[0]), .i_rx_data(rx_data0),
        .i_rx_done(rx_done[0]), .i_op_ready(ready[0]), .o_op_a(op_a0), .o_op_b(op_b0),
        .o_op_valid(valid0), .o_full(full0), .o_timeout_err(to0), .o_drop_err(drop0)
    );

    uart_fp_operand_assembler #(
        .SIZE_DATA(8), .SIZE_FP(32), .BYTE_LSB_FIRST(1'b0), .TIMEOUT_TICKS(0)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .i_stick(stick[1]), .i_rx_data(rx_data1),
        .i_rx_done(rx_done[1]), .i_op_ready(ready[1]), .o_op_a(op_a1), .o_op_b(op_b1),
        .o_op_valid(valid1), .o_full(full1), .o_timeout_err(to1), .o_drop_err(drop1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            held[d] = 1'b0; nb[d] = 0; gap[d] = 0;
            exp_drop[d] = 1'b0; exp_to[d] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_step(input int d, input bit done, input logic [7:0] data,
                              input bit stk, input bit rdy);
        logic [31:0] a, b;
        exp_drop[0] = 1'b0; exp_drop[1] = 1'b0;
        exp_to[0] = 1'b0;   exp_to[1] = 1'b0;
        if (held[d]) begin
            if (rdy) begin
                held[d] = 1'b0;
                nb[d] = 0;
                gap[d] = 0;
                if (done) begin
                    bq[d][0] = data;
                    nb[d] = 1;
                end
            end else if (done) begin
                exp_drop[d] = 1'b1;
            end
        end else if (done) begin
            bq[d][nb[d]] = data;
            nb[d]++;
            gap[d] = 0;
            if (nb[d] == 8) begin
                a = '0; b = '0;
                for (int k = 0; k < 4; k++) begin
                    if (lsb[d]) begin
                        a = a | (32'(bq[d][k]) << (8 * k));
                        b = b | (32'(bq[d][k + 4]) << (8 * k));
                    end else begin
                        a = a | (32'(bq[d][k]) << (24 - 8 * k));
                        b = b | (32'(bq[d][k + 4]) << (24 - 8 * k));
                    end
                end
                if (d == 0) q0.push_back({a, b}); else q1.push_back({a, b});
                held[d] = 1'b1;
                nb[d] = 0;
            end
        end else if (stk && nb[d] > 0 && tt[d] != 0) begin
            gap[d]++;
            if (gap[d] == tt[d]) begin
                exp_to[d] = 1'b1;
                nb[d] = 0;
                gap[d] = 0;
            end
        end
    endtask

    // One clock of stimulus for DUT d; the other DUT sees idle inputs.
    task automatic cyc(input int d, input bit done, input logic [7:0] data,
                       input bit stk, input bit rdy);
        rx_done = '0; stick = '0; ready = '0;
        rx_done[d] = done; stick[d] = stk; ready[d] = rdy;
        if (d == 0) rx_data0 = data; else rx_data1 = data;
        @(posedge clk);
        model_step(d, done, data, stk, rdy);
        #1;
    endtask

    task automatic idle(input int d, input int n, input bit rdy);
        repeat (n) cyc(d, 1'b0, 8'h00, 1'b0, rdy);
    endtask

    task automatic send_rand(input int d, input int n, input bit rdy);
        repeat (n) cyc(d, 1'b1, 8'($urandom), 1'b0, rdy);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_a0"}, op_a0, 0);   chk({tag, "_b0"}, op_b0, 0);
        chk({tag, "_a1"}, op_a1, 0);   chk({tag, "_b1"}, op_b1, 0);
        chk({tag, "_flags0"}, {valid0, full0, to0, drop0}, 0);
        chk({tag, "_flags1"}, {valid1, full1, to1, drop1}, 0);
    endtask

    task automatic do_reset();
        rx_done = '0; stick = '0; ready = '0;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_dut(input int d, input logic [31:0] a, input logic [31:0] b,
                             input logic v, input logic f, input logic te, input logic de);
        logic [63:0] e;
        bit have;
        chk($sformatf("valid%0d", d), v, held[d]);
        chk($sformatf("full%0d", d), f, held[d]);
        chk($sformatf("drop_err%0d", d), de, exp_drop[d]);
        chk($sformatf("timeout_err%0d", d), te, exp_to[d]);
        if (v) begin
            have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!have) begin
                n_checks++;
                n_fail++;
                $display("FAIL pair%0d: got %h_%h expected nothing pending", d, a, b);
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                chk($sformatf("pair%0d", d), {a, b}, e);
                if (ready[d]) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check_dut(0, op_a0, op_b0, valid0, full0, to0, drop0);
            check_dut(1, op_a1, op_b1, valid1, full1, to1, drop1);
        end
    end

    logic [7:0] fp_stream[8] = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h40};

    initial begin
        model_reset();
        #3;
        check_zero_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1.0f / 2.0f stream into both byte orders, ready held high
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) cyc(d, 1'b1, fp_stream[i], 1'b0, 1'b1);
            idle(d, 3, 1'b1);
        end

        // Byte while held and not ready is dropped
        send_rand(0, 8, 1'b0);
        idle(0, 2, 1'b0);
        cyc(0, 1'b1, 8'hAA, 1'b0, 1'b0);
        idle(0, 3, 1'b0);
        idle(0, 3, 1'b1);

        // Byte coincident with handshake starts the next A
        send_rand(0, 8, 1'b0);
        idle(0, 2, 1'b0);
        cyc(0, 1'b1, 8'h11, 1'b0, 1'b1);
        send_rand(0, 7, 1'b0);
        idle(0, 2, 1'b0);
        idle(0, 1, 1'b1);
        send_rand(0, 8, 1'b1);
        idle(0, 2, 1'b1);

        // Gap timeout after 3 bytes, then a fresh pair
        send_rand(0, 3, 1'b1);
        for (int t = 0; t < 8; t++) begin
            cyc(0, 1'b0, 8'h00, 1'b1, 1'b1);
            idle(0, 2, 1'b1);
        end
        send_rand(0, 8, 1'b1);
        idle(0, 2, 1'b1);

        // Byte coincident with the limit tick wins; reset mid COLLECT_B
        send_rand(0, 3, 1'b1);
        for (int t = 0; t < 7; t++) begin
            cyc(0, 1'b0, 8'h00, 1'b1, 1'b1);
            idle(0, 1, 1'b1);
        end
        cyc(0, 1'b1, 8'h5A, 1'b1, 1'b1);
        for (int t = 0; t < 9; t++) cyc(0, 1'b0, 8'h00, 1'b1, 1'b1);
        send_rand(0, 6, 1'b1);
        do_reset();
        send_rand(0, 8, 1'b1);
        idle(0, 2, 1'b1);

        // Randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            repeat (500) begin
                cyc(d, ($urandom_range(0, 2) == 0), 8'($urandom),
                    ($urandom_range(0, 3) == 0), 1'($urandom));
            end
            idle(d, 2, 1'b1);
        end

        chk("queue0_drained", 64'(q0.size()), 64'd0);
        chk("queue1_drained", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
